// File: rtl/ttl_parity_frame_receiver_pkg.sv
// Shared types and line-level constants for the serial parity frame receiver.
package ttl_parity_frame_receiver_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/ttl_parity_frame_receiver_parity_tree.sv
// Combinational reduction XOR: odd is 1 when the word holds an odd number of ones.
module ttl_parity_frame_receiver_parity_tree #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  odd
);

  assign odd = ^data;

endmodule

// File: rtl/ttl_parity_frame_receiver.sv
// Strobe-qualified serial frame receiver: start, DATA_WIDTH bits LSB-first, parity, stop.
// Commits the word with parity/framing flags and a one-cycle q_valid pulse.
module ttl_parity_frame_receiver
  import ttl_parity_frame_receiver_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  ser,
  input  logic                  ser_valid,
  input  logic                  odd_sel,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  output logic                  perr,
  output logic                  ferr,
  output logic                  busy,
  output state_t                dbg_state
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  // ser is consumed on every clk edge where ser_valid=1; there is no back-pressure,
  // and q_valid is a single-cycle pulse that the consumer must catch.
  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  pbit;
  logic                  odd_lat;
  logic                  data_odd;

  ttl_parity_frame_receiver_parity_tree #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity_tree (
    .data (shreg),
    .odd  (data_odd)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      pbit    <= 1'b0;
      odd_lat <= 1'b0;
      q       <= '0;
      q_valid <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      q_valid <= 1'b0;
      // Abort overrides any sample in the same edge, including the stop bit.
      if (abort) begin
        state <= IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else if (ser_valid) begin
        case (state)
          IDLE: begin
            if (ser == START_BIT) begin
              state <= DATA;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          DATA: begin
            shreg[cnt] <= ser;
            if (cnt == LAST) begin
              state <= PARITY;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PARITY: begin
            pbit    <= ser;
            odd_lat <= odd_sel;
            state   <= STOP;
          end
          STOP: begin
            q       <= shreg;
            perr    <= ((data_odd ^ pbit) != odd_lat);
            ferr    <= (ser != STOP_BIT);
            q_valid <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dbg_state = state;

endmodule
